// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor control stage:
// 2-bit saturating counter encoding, occupancy FSM states, counter update.
package bp_pkg;

    // 2-bit pattern history counter; bit 1 is the taken prediction.
    typedef logic [1:0] counter_t;

    localparam counter_t SNT = 2'b00;  // strong not-taken
    localparam counter_t WNT = 2'b01;  // weak not-taken
    localparam counter_t WT  = 2'b10;  // weak taken
    localparam counter_t ST  = 2'b11;  // strong taken

    // Occupancy of the in-flight FIFO.
    typedef enum logic [1:0] {
        StEmpty,
        StPartial,
        StFull
    } occ_state_e;

    // Saturating update: taken counts up to ST, not-taken counts down to SNT.
    function automatic counter_t sat_update(input counter_t c, input logic taken);
        counter_t r;
        if (taken) begin
            r = (c == ST) ? ST : counter_t'(c + 2'd1);
        end else begin
            r = (c == SNT) ? SNT : counter_t'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-flight branch FIFO: stores {index, counter snapshot, prediction} per
// branch in fetch order. On a pop, every other live entry sharing the popped
// entry's index picks up the freshly resolved counter value so that later
// resolves update from the newest state rather than a stale snapshot.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = 4,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [ADDRESS_BITS-1:0]   push_index,
    input  counter_t                  push_snapshot,
    input  logic                      push_pred,
    input  logic                      pop,
    input  logic                      flush,
    input  counter_t                  pop_value,
    output logic [ADDRESS_BITS-1:0]   head_index,
    output counter_t                  head_snapshot,
    output logic                      head_pred,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    typedef logic [PTR_BITS-1:0] ptr_t;
    typedef logic [CNT_BITS-1:0] cnt_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam cnt_t CNT_ONE = cnt_t'(1);

    logic [ADDRESS_BITS-1:0] index_q [DEPTH];
    counter_t                snap_q  [DEPTH];
    logic [DEPTH-1:0]        pred_q;
    logic [DEPTH-1:0]        valid_q;
    ptr_t                    rd_ptr_q;
    ptr_t                    wr_ptr_q;
    cnt_t                    count_q;

    assign head_index    = index_q[rd_ptr_q];
    assign head_snapshot = snap_q[rd_ptr_q];
    assign head_pred     = pred_q[rd_ptr_q];
    assign count         = count_q;

    // Entry storage, forwarding overwrite, pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                index_q[i] <= '0;
                snap_q[i]  <= SNT;
            end
            pred_q   <= '0;
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Younger same-index entries adopt the value just written back.
            for (int i = 0; i < DEPTH; i++) begin
                if (pop && valid_q[i] && (ptr_t'(i) != rd_ptr_q) &&
                    (index_q[i] == head_index)) begin
                    snap_q[i] <= pop_value;
                end
            end

            // A push never lands on a live slot, so it can follow the forward.
            if (push) begin
                index_q[wr_ptr_q] <= push_index;
                snap_q[wr_ptr_q]  <= push_snapshot;
                pred_q[wr_ptr_q]  <= push_pred;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_ONE;
            end

            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_ONE;
            end

            if (flush) begin
                valid_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else if (push && !pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor control stage in front of a 2-bit pattern history buffer.
// Issues predictions for fetch lookups, tracks in-flight branches and writes
// saturating-counter updates back as branches resolve in order.
// Optional statistics counters are enabled with the macro BRANCH_STATS_EN.
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = 4,
    parameter int unsigned PC_BITS      = 32,
    parameter int unsigned INDEX_LSB    = 2,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    lookup_valid,
    input  logic [PC_BITS-1:0]      lookup_pc,
    output logic                    lookup_ready,
    output logic                    pred_valid,
    output logic                    pred_taken,
    input  logic                    resolve_valid,
    input  logic                    resolve_taken,
    input  logic                    resolve_flush,
    output logic                    mispredict,
    output logic                    resolve_error,
    output logic [ADDRESS_BITS-1:0] read_address,
    input  logic [1:0]              read_value,
    output logic [ADDRESS_BITS-1:0] write_address,
`ifdef BRANCH_STATS_EN
    output logic [15:0]             stat_resolved,
    output logic [15:0]             stat_mispredicts,
`endif
    output logic [1:0]              write_value
);

    localparam int unsigned CNT_BITS = $clog2(DEPTH) + 1;

    typedef logic [CNT_BITS-1:0] cnt_t;

    localparam cnt_t CNT_LAST_FREE = cnt_t'(DEPTH - 1);
    localparam cnt_t CNT_ONE       = cnt_t'(1);

    logic [ADDRESS_BITS-1:0] lookup_index;
    logic [ADDRESS_BITS-1:0] head_index;
    counter_t                head_snapshot;
    logic                    head_pred;
    cnt_t                    count;
    counter_t                resolved_value;
    counter_t                effective;
    logic                    fifo_empty;
    logic                    honoured;
    logic                    flush;
    logic                    accept;
    logic                    miss;
    occ_state_e              state_q;
    logic                    unused_pc;

    // Only the index bits of the PC matter; fold the rest away.
    assign unused_pc = ^lookup_pc;

    assign lookup_index   = lookup_pc[INDEX_LSB +: ADDRESS_BITS];
    assign read_address   = lookup_index;
    assign fifo_empty     = (state_q == StEmpty);
    assign honoured       = resolve_valid && !fifo_empty;
    assign flush          = honoured && resolve_flush;
    // lookup_ready is registered, so a pop while full cannot admit a lookup.
    assign accept         = lookup_valid && lookup_ready && !flush;
    assign resolved_value = sat_update(head_snapshot, resolve_taken);
    assign miss           = honoured && (head_pred != resolve_taken);

    // Same-cycle update to the looked-up index overrides the stale buffer read.
    always_comb begin
        effective = read_value;
        if (honoured && (head_index == lookup_index)) begin
            effective = resolved_value;
        end
    end

    // The buffer writes every cycle; without a resolve, rewrite what was read.
    always_comb begin
        write_address = read_address;
        write_value   = read_value;
        if (honoured) begin
            write_address = head_index;
            write_value   = resolved_value;
        end
    end

    bp_inflight_fifo #(
        .ADDRESS_BITS (ADDRESS_BITS),
        .DEPTH        (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push          (accept),
        .push_index    (lookup_index),
        .push_snapshot (effective),
        .push_pred     (effective[1]),
        .pop           (honoured),
        .flush         (flush),
        .pop_value     (resolved_value),
        .head_index    (head_index),
        .head_snapshot (head_snapshot),
        .head_pred     (head_pred),
        .count         (count)
    );

    // Occupancy FSM with registered prediction, mispredict and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StEmpty;
            lookup_ready  <= 1'b1;
            pred_valid    <= 1'b0;
            pred_taken    <= 1'b0;
            mispredict    <= 1'b0;
            resolve_error <= 1'b0;
        end else begin
            pred_valid <= accept;
            pred_taken <= accept && effective[1];
            mispredict <= miss;
            if (resolve_valid && fifo_empty) begin
                resolve_error <= 1'b1;
            end

            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q      <= StPartial;
                        lookup_ready <= 1'b1;
                    end
                end
                StPartial: begin
                    if (flush) begin
                        state_q      <= StEmpty;
                        lookup_ready <= 1'b1;
                    end else if (accept && !honoured && (count == CNT_LAST_FREE)) begin
                        state_q      <= StFull;
                        lookup_ready <= 1'b0;
                    end else if (honoured && !accept && (count == CNT_ONE)) begin
                        state_q      <= StEmpty;
                        lookup_ready <= 1'b1;
                    end
                end
                StFull: begin
                    if (flush) begin
                        state_q      <= StEmpty;
                        lookup_ready <= 1'b1;
                    end else if (honoured) begin
                        state_q      <= StPartial;
                        lookup_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= StEmpty;
                    lookup_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating counts of honoured resolves and of mispredicted resolves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_resolved    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (honoured && (stat_resolved != 16'hFFFF)) begin
                stat_resolved <= stat_resolved + 16'd1;
            end
            if (miss && (stat_mispredicts != 16'hFFFF)) begin
                stat_mispredicts <= stat_mispredicts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with a behavioural 16-entry
// pattern history buffer attached to its read/write ports.
module tb_branch_predict_ctrl;

    logic        clk;
    logic        reset;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        lookup_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        resolve_flush;
    logic        mispredict;
    logic        resolve_error;
    logic [3:0]  read_address;
    logic [1:0]  read_value;
    logic [3:0]  write_address;
    logic [1:0]  write_value;

    logic [1:0]  mem [16];

    int checks = 0;
    int errors = 0;

    // Expected values for the four taken resolves at index 4.
    logic [1:0] exp_wr   [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    logic       exp_pred [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_mis  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    branch_predict_ctrl #(
        .ADDRESS_BITS (4),
        .PC_BITS      (32),
        .INDEX_LSB    (2),
        .DEPTH        (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .lookup_valid  (lookup_valid),
        .lookup_pc     (lookup_pc),
        .lookup_ready  (lookup_ready),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .resolve_flush (resolve_flush),
        .mispredict    (mispredict),
        .resolve_error (resolve_error),
        .read_address  (read_address),
        .read_value    (read_value),
        .write_address (write_address),
        .write_value   (write_value)
    );

    always #5 clk = ~clk;

    // Buffer model: combinational read, unconditional write every clock.
    assign read_value = mem[read_address];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 2'b00;
            end
            mem[7] <= 2'b01;
            mem[5] <= 2'b10;
        end else begin
            mem[write_address] <= write_value;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk           = 1'b0;
        reset         = 1'b0;
        lookup_valid  = 1'b0;
        lookup_pc     = 32'h0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        resolve_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state
        check("rst_ready",   32'(lookup_ready),  32'd1);
        check("rst_pvalid",  32'(pred_valid),    32'd0);
        check("rst_ptaken",  32'(pred_taken),    32'd0);
        check("rst_mispred", 32'(mispredict),    32'd0);
        check("rst_error",   32'(resolve_error), 32'd0);

        // Lookup pc 0x10 -> index 4, counter 00
        lookup_valid = 1'b1;
        lookup_pc    = 32'h10;
        #1;
        check("t1_raddr", 32'(read_address),  32'd4);
        check("t1_waddr", 32'(write_address), 32'd4);
        check("t1_wval",  32'(write_value),   32'd0);
        tick;
        lookup_valid = 1'b0;
        check("t1_pvalid", 32'(pred_valid),   32'd1);
        check("t1_ptaken", 32'(pred_taken),   32'd0);
        check("t1_ready",  32'(lookup_ready), 32'd1);

        // Four taken resolves at index 4, one branch in flight at a time
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                lookup_valid = 1'b1;
                lookup_pc    = 32'h10;
                tick;
                lookup_valid = 1'b0;
                check("t2_pvalid", 32'(pred_valid), 32'd1);
                check("t2_ptaken", 32'(pred_taken), 32'(exp_pred[k]));
            end
            resolve_valid = 1'b1;
            resolve_taken = 1'b1;
            #1;
            check("t2_waddr", 32'(write_address), 32'd4);
            check("t2_wval",  32'(write_value),   32'(exp_wr[k]));
            tick;
            resolve_valid = 1'b0;
            check("t2_mispred", 32'(mispredict), 32'(exp_mis[k]));
            check("t2_mem4",    32'(mem[4]),     32'(exp_wr[k]));
        end

        // Two lookups at index 7 (01); second snapshot forwarded to 10
        lookup_valid = 1'b1;
        lookup_pc    = 32'h1C;
        tick;
        check("t3_pvalid_a", 32'(pred_valid), 32'd1);
        check("t3_ptaken_a", 32'(pred_taken), 32'd0);
        tick;
        lookup_valid = 1'b0;
        check("t3_pvalid_b", 32'(pred_valid), 32'd1);
        check("t3_ptaken_b", 32'(pred_taken), 32'd0);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        #1;
        check("t3_waddr_a", 32'(write_address), 32'd7);
        check("t3_wval_a",  32'(write_value),   32'd2);
        tick;
        check("t3_mispred_a", 32'(mispredict), 32'd1);
        #1;
        check("t3_wval_b", 32'(write_value), 32'd3);
        tick;
        resolve_valid = 1'b0;
        check("t3_mispred_b", 32'(mispredict),   32'd1);
        check("t3_mem7",      32'(mem[7]),       32'd3);
        check("t3_ready",     32'(lookup_ready), 32'd1);

        // Same-cycle resolve and lookup at index 5 (10): lookup sees bypassed 01
        lookup_valid = 1'b1;
        lookup_pc    = 32'h14;
        tick;
        check("t4_ptaken_a", 32'(pred_taken), 32'd1);
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        #1;
        check("t4_waddr", 32'(write_address), 32'd5);
        check("t4_wval",  32'(write_value),   32'd1);
        tick;
        lookup_valid  = 1'b0;
        resolve_valid = 1'b0;
        check("t4_pvalid",  32'(pred_valid),   32'd1);
        check("t4_ptaken",  32'(pred_taken),   32'd0);
        check("t4_mispred", 32'(mispredict),   32'd1);
        check("t4_ready",   32'(lookup_ready), 32'd1);
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        #1;
        check("t4_wval_b", 32'(write_value), 32'd0);
        tick;
        resolve_valid = 1'b0;
        check("t4_mispred_b", 32'(mispredict), 32'd0);
        check("t4_mem5",      32'(mem[5]),     32'd0);

        // Fill the FIFO with four lookups at index 0
        lookup_valid = 1'b1;
        lookup_pc    = 32'h0;
        repeat (3) tick;
        check("t5_ready_3", 32'(lookup_ready), 32'd1);
        tick;
        check("t5_pvalid_4", 32'(pred_valid),   32'd1);
        check("t5_ready_4",  32'(lookup_ready), 32'd0);
        tick;
        check("t5_pvalid_5", 32'(pred_valid),   32'd0);
        check("t5_ready_5",  32'(lookup_ready), 32'd0);
        // Resolve while full: no pass-through for the waiting lookup
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        #1;
        check("t5_ready_pop", 32'(lookup_ready),  32'd0);
        check("t5_waddr",     32'(write_address), 32'd0);
        check("t5_wval",      32'(write_value),   32'd1);
        tick;
        check("t5_pvalid_pop", 32'(pred_valid),   32'd0);
        check("t5_ready_after", 32'(lookup_ready), 32'd1);
        check("t5_mispred",    32'(mispredict),   32'd1);
        check("t5_mem0",       32'(mem[0]),       32'd1);
        // Push and pop together; forwarded head 01 -> 10, lookup bypasses to 10
        #1;
        check("t5_wval_b", 32'(write_value), 32'd2);
        tick;
        check("t5_pvalid_pp", 32'(pred_valid),   32'd1);
        check("t5_ptaken_pp", 32'(pred_taken),   32'd1);
        check("t5_ready_pp",  32'(lookup_ready), 32'd1);

        // Flush with three in flight, head snapshot 10, not taken
        resolve_taken = 1'b0;
        resolve_flush = 1'b1;
        #1;
        check("t6_waddr", 32'(write_address), 32'd0);
        check("t6_wval",  32'(write_value),   32'd1);
        tick;
        lookup_valid  = 1'b0;
        resolve_valid = 1'b0;
        resolve_flush = 1'b0;
        check("t6_pvalid",  32'(pred_valid),   32'd0);
        check("t6_mispred", 32'(mispredict),   32'd0);
        check("t6_ready",   32'(lookup_ready), 32'd1);
        check("t6_mem0",    32'(mem[0]),       32'd1);
        // FIFO must be empty: a new lookup is the head on the next resolve
        lookup_valid = 1'b1;
        tick;
        lookup_valid = 1'b0;
        check("t6_ptaken_new", 32'(pred_taken), 32'd0);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        #1;
        check("t6_wval_new", 32'(write_value), 32'd2);
        tick;
        resolve_valid = 1'b0;
        check("t6_mispred_new", 32'(mispredict), 32'd1);

        // Resolve with the FIFO empty
        lookup_pc     = 32'h1C;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        #1;
        check("t7_waddr", 32'(write_address), 32'd7);
        check("t7_wval",  32'(write_value),   32'd3);
        tick;
        resolve_valid = 1'b0;
        check("t7_error",   32'(resolve_error), 32'd1);
        check("t7_mispred", 32'(mispredict),    32'd0);
        check("t7_mem7",    32'(mem[7]),        32'd3);
        repeat (3) tick;
        check("t7_error_sticky", 32'(resolve_error), 32'd1);
        check("t7_mem0",         32'(mem[0]),        32'd2);
        lookup_valid = 1'b1;
        lookup_pc    = 32'h0;
        tick;
        lookup_valid = 1'b0;
        check("t7_pvalid", 32'(pred_valid), 32'd1);
        check("t7_ptaken", 32'(pred_taken), 32'd1);

        // Asynchronous reset clears the sticky error immediately
        #2;
        reset = 1'b0;
        #1;
        check("t8_error",  32'(resolve_error), 32'd0);
        check("t8_pvalid", 32'(pred_valid),    32'd0);
        check("t8_ready",  32'(lookup_ready),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
